// File: rtl/keyboard_pkg.sv
// Shared key codes and PS/2 scan-code constants for the keyboard receiver.
package keyboard_pkg;

    localparam int unsigned KeyWidth = 3;

    // Game key codes reported on the key output
    localparam logic [KeyWidth-1:0] KEY_NONE  = 3'd0;
    localparam logic [KeyWidth-1:0] KEY_UP    = 3'd1;
    localparam logic [KeyWidth-1:0] KEY_DOWN  = 3'd2;
    localparam logic [KeyWidth-1:0] KEY_LEFT  = 3'd3;
    localparam logic [KeyWidth-1:0] KEY_RIGHT = 3'd4;
    localparam logic [KeyWidth-1:0] KEY_SPACE = 3'd5;

    // PS/2 set-2 scan codes
    localparam logic [7:0] SCAN_BREAK  = 8'hF0;
    localparam logic [7:0] SCAN_EXPAND = 8'hE0;
    localparam logic [7:0] SCAN_UP     = 8'h75;
    localparam logic [7:0] SCAN_DOWN   = 8'h72;
    localparam logic [7:0] SCAN_LEFT   = 8'h6B;
    localparam logic [7:0] SCAN_RIGHT  = 8'h74;
    localparam logic [7:0] SCAN_SPACE  = 8'h29;

    // Bit indices within an 11-bit frame
    localparam logic [3:0] BIT_START  = 4'd0;
    localparam logic [3:0] BIT_PARITY = 4'd9;
    localparam logic [3:0] BIT_STOP   = 4'd10;

    // Map a scan code to a game key; KEY_NONE means "not a game key".
    function automatic logic [KeyWidth-1:0] scan_to_key(input logic [7:0] code);
        logic [KeyWidth-1:0] k;
        k = KEY_NONE;
        case (code)
            SCAN_UP:    k = KEY_UP;
            SCAN_DOWN:  k = KEY_DOWN;
            SCAN_LEFT:  k = KEY_LEFT;
            SCAN_RIGHT: k = KEY_RIGHT;
            SCAN_SPACE: k = KEY_SPACE;
            default:    k = KEY_NONE;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/keyboard.sv
// PS/2 keyboard receiver: synchronises PS2_clk, captures 11-bit frames and
// decodes make/break of the game keys (arrows and space).
module keyboard
    import keyboard_pkg::*;
(
    input  logic                clk,
    input  logic                rstn,
    input  logic                PS2_clk,
    input  logic                PS2_data,
    output logic [KeyWidth-1:0] key,
    output logic                key_state
);

    logic [2:0] PS2_clk_flag;
    logic       negedge_PS2_clk;
    logic [3:0] num;
    logic [7:0] temp_data;
    logic       byte_valid;
    logic       break_flag;
    logic       expand_flag;
    logic [KeyWidth-1:0] mapped_key;

    // Shift PS2_clk into a 3-stage synchroniser; reset to all-ones so idle is not an edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            PS2_clk_flag <= 3'b111;
        end else begin
            PS2_clk_flag <= {PS2_clk_flag[1:0], PS2_clk};
        end
    end

    assign negedge_PS2_clk = PS2_clk_flag[2] & ~PS2_clk_flag[1];

    // Count frame bits on each falling edge, store data LSB first, flag frame completion
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            num        <= 4'd0;
            temp_data  <= 8'h00;
            byte_valid <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (negedge_PS2_clk) begin
                if (num == BIT_STOP) begin
                    num        <= 4'd0;
                    byte_valid <= 1'b1;
                end else begin
                    // Start (0) and parity (9) bits are deliberately ignored
                    if (num != BIT_START && num != BIT_PARITY) begin
                        temp_data[num[2:0] - 3'd1] <= PS2_data;
                    end
                    num <= num + 4'd1;
                end
            end
        end
    end

    assign mapped_key = scan_to_key(temp_data);

    // Decode a completed byte: accumulate prefixes, or update the key on a game scan code
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            key         <= KEY_NONE;
            key_state   <= 1'b0;
            break_flag  <= 1'b0;
            expand_flag <= 1'b0;
        end else if (byte_valid) begin
            if (temp_data == SCAN_BREAK) begin
                break_flag <= 1'b1;
            end else if (temp_data == SCAN_EXPAND) begin
                expand_flag <= 1'b1;
            end else begin
                // Arrow codes are taken with or without E0; expand_flag only needs clearing
                if (mapped_key != KEY_NONE) begin
                    key       <= mapped_key;
                    key_state <= ~break_flag;
                end
                break_flag  <= 1'b0;
                expand_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keyboard.sv
// Directed self-checking bench for the PS/2 keyboard receiver.
module tb_keyboard;

    logic       clk;
    logic       rstn;
    logic       PS2_clk;
    logic       PS2_data;
    logic [2:0] key;
    logic       key_state;

    int tests;
    int fails;
    int pulses;
    int pulses_before;

    keyboard dut (
        .clk       (clk),
        .rstn      (rstn),
        .PS2_clk   (PS2_clk),
        .PS2_data  (PS2_data),
        .key       (key),
        .key_state (key_state)
    );

    initial clk = 1'b0;
    always #1 clk = ~clk;

    // Count detected falling edges of PS2_clk
    always @(posedge clk) begin
        if (dut.negedge_PS2_clk === 1'b1) pulses <= pulses + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One PS/2 bit: data set while clock high, clock low 10 ns, high 10 ns
    task automatic send_bit(input logic b);
        PS2_data = b;
        #5 PS2_clk = 1'b0;
        #10 PS2_clk = 1'b1;
        #5;
    endtask

    task automatic send_frame(input logic [7:0] d);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(~^d);
        send_bit(1'b1);
        #40;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        pulses = 0;
        PS2_clk = 1'b1;
        PS2_data = 1'b1;
        rstn = 1'b0;
        #20 rstn = 1'b1;
        #9;
        check("reset_key", int'(key), 0);
        check("reset_state", int'(key_state), 0);
        check("reset_num", int'(dut.num), 0);

        // Space make
        pulses_before = pulses;
        send_frame(8'h29);
        check("space_temp", int'(dut.temp_data), 8'h29);
        check("space_key", int'(key), 5);
        check("space_state", int'(key_state), 1);
        check("space_num", int'(dut.num), 0);
        check("space_pulses", pulses - pulses_before, 11);

        // Extended up make
        send_frame(8'hE0);
        check("e0_key_hold", int'(key), 5);
        send_frame(8'h75);
        check("up_key", int'(key), 1);
        check("up_state", int'(key_state), 1);

        // F0,E0 break of up
        send_frame(8'hF0);
        check("f0_state_hold", int'(key_state), 1);
        send_frame(8'hE0);
        send_frame(8'h75);
        check("up_brk_key", int'(key), 1);
        check("up_brk_state", int'(key_state), 0);

        // E0,F0 order also works: left break after left make
        send_frame(8'h6B);
        check("left_key", int'(key), 3);
        check("left_state", int'(key_state), 1);
        send_frame(8'hE0);
        send_frame(8'hF0);
        send_frame(8'h6B);
        check("left_brk_state", int'(key_state), 0);

        // Space break
        pulses_before = pulses;
        send_frame(8'hF0);
        send_frame(8'h29);
        check("space_brk_key", int'(key), 5);
        check("space_brk_state", int'(key_state), 0);
        check("space_brk_num", int'(dut.num), 0);
        check("space_brk_pulses", pulses - pulses_before, 22);

        // Right make then an unknown byte leaves outputs untouched
        send_frame(8'h74);
        check("right_key", int'(key), 4);
        check("right_state", int'(key_state), 1);
        send_frame(8'h1C);
        check("unk_key", int'(key), 4);
        check("unk_state", int'(key_state), 1);
        // Unknown byte must have cleared the flags: space now reads as make
        send_frame(8'hF0);
        send_frame(8'h1C);
        send_frame(8'h29);
        check("flag_clr_state", int'(key_state), 1);

        // Reset mid-frame after four bits
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check("mid_num", int'(dut.num), 4);
        rstn = 1'b0;
        #20 rstn = 1'b1;
        #9;
        check("mid_rst_num", int'(dut.num), 0);
        check("mid_rst_key", int'(key), 0);
        check("mid_rst_state", int'(key_state), 0);
        send_frame(8'h72);
        check("down_temp", int'(dut.temp_data), 8'h72);
        check("down_key", int'(key), 2);
        check("down_state", int'(key_state), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
